stats_engine: RTL

//  Parametrised successor to the switch-driven statistics block. Samples din on a periodic tick:

---
 rtl/stats_pkg.sv | 31 +++
 rtl/stats_divsqrt.sv | 138 +++++++++++++
 rtl/stats_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/stats_pkg.sv
// Shared types and constants for the statistics engine.
package stats_pkg;

    // Top-level FSM; the encoding is exported on the phase port for debug LEDs.
    typedef enum logic [2:0] {
        LOAD_N  = 3'd0,
        LOAD_S  = 3'd1,
        SELECT  = 3'd2,
        COMPUTE = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // Divider/sqrt unit sequencing.
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_DIV1 = 2'd1,
        DS_DIV2 = 2'd2,
        DS_SQRT = 2'd3
    } ds_state_t;

    localparam logic [1:0] MODE_SUM   = 2'd0;
    localparam logic [1:0] MODE_AVG   = 2'd1;
    localparam logic [1:0] MODE_SUMSQ = 2'd2;
    localparam logic [1:0] MODE_STD   = 2'd3;

    // Accumulator width: enough for DEPTH squared samples without overflow.
    function automatic int acc_w(input int w, input int depth);
        return 2 * w + $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stats_divsqrt.sv
// Shared sequential arithmetic unit: restoring divider (one quotient bit per
// cycle) and non-restoring integer square root (one root bit per cycle).
// op=0: res = sum / n after ACC_W cycles.
// op=1: res = isqrt(sumsq/n - (sum/n)^2) after 2*ACC_W + ceil(ACC_W/2) cycles.
// start loads the operands on the same edge; done is a one-cycle pulse with
// res valid in that cycle. start is only issued while the unit is idle.
module stats_divsqrt
    import stats_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [ACC_W-1:0] sum,
    input  logic [ACC_W-1:0] sumsq,
    input  logic [ACC_W-1:0] n,
    output logic             done,
    output logic [ACC_W-1:0] res
);

    localparam int SQ_STEPS = (ACC_W + 1) / 2;
    localparam int RAD_W    = 2 * SQ_STEPS;
    localparam int SR_W     = RAD_W + 4;
    localparam int CW       = $clog2(ACC_W + 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(ACC_W - 1);
    localparam logic [CW-1:0] LAST_SQ  = CW'(SQ_STEPS - 1);

    ds_state_t                 st;
    logic                      op_r;
    logic [CW-1:0]             cnt;
    logic [ACC_W-1:0]          rem, quo, divisor, sumsq_r, mean_r;
    logic [2*ACC_W-1:0]        msq;
    logic [RAD_W-1:0]          rad;
    logic signed [SR_W-1:0]    sr;
    logic [SQ_STEPS-1:0]       root;

    // Divider step: bring down the next dividend bit, subtract if it fits.
    logic [ACC_W:0]     shifted;
    logic               ge;
    logic [ACC_W-1:0]   rem_next, quo_next;
    logic [2*ACC_W-1:0] q2w, rad_val;
    assign shifted  = {rem, quo[ACC_W-1]};
    assign ge       = (shifted >= {1'b0, divisor});
    assign rem_next = ge ? ACC_W'(shifted - {1'b0, divisor}) : shifted[ACC_W-1:0];
    assign quo_next = {quo[ACC_W-2:0], ge};
    // Variance = E[x^2] - mean^2, clamped at zero (floor division can undershoot).
    assign q2w      = {{ACC_W{1'b0}}, quo_next};
    assign rad_val  = (q2w >= msq) ? (q2w - msq) : '0;

    // Sqrt step: signed remainder; subtract 4Q+1 when non-negative, else add 4Q+3.
    logic signed [SR_W-1:0] sr_shift, q41, q43, sr_next;
    logic [SQ_STEPS-1:0]    root_next;
    assign sr_shift  = (sr <<< 2) + $signed({{(SR_W-2){1'b0}}, rad[RAD_W-1 -: 2]});
    assign q41       = $signed({{(SR_W-SQ_STEPS-2){1'b0}}, root, 2'b01});
    assign q43       = $signed({{(SR_W-SQ_STEPS-2){1'b0}}, root, 2'b11});
    assign sr_next   = sr[SR_W-1] ? (sr_shift + q43) : (sr_shift - q41);
    assign root_next = {root[SQ_STEPS-2:0], ~sr_next[SR_W-1]};

    // Sequencer: DIV1 (sum/n), optionally DIV2 (sumsq/n) then SQRT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= DS_IDLE;
            op_r    <= 1'b0;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            sumsq_r <= '0;
            mean_r  <= '0;
            msq     <= '0;
            rad     <= '0;
            sr      <= '0;
            root    <= '0;
            done    <= 1'b0;
            res     <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                st      <= DS_DIV1;
                op_r    <= op;
                cnt     <= '0;
                rem     <= '0;
                quo     <= sum;
                divisor <= n;
                sumsq_r <= sumsq;
            end else begin
                case (st)
                    DS_DIV1: begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_DIV) begin
                            cnt <= '0;
                            if (!op_r) begin
                                res  <= quo_next;
                                done <= 1'b1;
                                st   <= DS_IDLE;
                            end else begin
                                mean_r <= quo_next;
                                rem    <= '0;
                                quo    <= sumsq_r;
                                st     <= DS_DIV2;
                            end
                        end
                    end
                    DS_DIV2: begin
                        rem <= rem_next;
                        quo <= quo_next;
                        msq <= (2*ACC_W)'(mean_r) * (2*ACC_W)'(mean_r);
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_DIV) begin
                            cnt  <= '0;
                            rad  <= RAD_W'(rad_val);
                            sr   <= '0;
                            root <= '0;
                            st   <= DS_SQRT;
                        end
                    end
                    DS_SQRT: begin
                        sr   <= sr_next;
                        root <= root_next;
                        rad  <= rad << 2;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_SQ) begin
                            res  <= ACC_W'(root_next);
                            done <= 1'b1;
                            st   <= DS_IDLE;
                        end
                    end
                    default: st <= DS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/stats_engine.sv
// Switch-driven statistics engine: captures N, N samples and a mode code on
// a periodic tick, then shows sum / mean / sum of squares / std deviation,
// saturated to OUT_W bits.
module stats_engine
    import stats_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEPTH       = 10,
    parameter int OUT_W       = 8,
    parameter int TICK_CYCLES = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       phase
);

    localparam int ACC_W = acc_w(W, DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);
    localparam int TCW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = OUT_W'(v);
        if ((v >> OUT_W) != '0) r = '1;
        return r;
    endfunction

    logic [TCW-1:0]   tcnt;
    logic             tick;
    state_t           state;
    logic [NW-1:0]    n, idx, n_in;
    logic [ACC_W-1:0] sum, sumsq, direct_val, ds_res;
    logic [1:0]       mode, din_mode;
    logic             use_div, need_div, ds_start, ds_done;

    assign tick       = (tcnt == TCW'(TICK_CYCLES - 1));
    assign n_in       = (32'(din) > DEPTH) ? NW'(DEPTH) : NW'(din);
    assign din_mode   = (32'(din) >= 32'd3) ? MODE_STD : din[1:0];
    // Odd modes (mean, std) need the divider; an empty set never starts it.
    assign need_div   = (n != '0) && din_mode[0];
    assign ds_start   = tick && need_div &&
                        ((state == SELECT) || ((state == SHOW) && (din_mode != mode)));
    assign direct_val = (n == '0) ? '0 : ((mode == MODE_SUMSQ) ? sumsq : sum);
    assign phase      = state;

    // Free-running tick divider: one-cycle tick every TICK_CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    stats_divsqrt #(.ACC_W(ACC_W)) u_divsqrt (
        .clk   (clk),
        .rst   (rst),
        .start (ds_start),
        .op    (din_mode[1]),
        .sum   (sum),
        .sumsq (sumsq),
        .n     (ACC_W'(n)),
        .done  (ds_done),
        .res   (ds_res)
    );

    // Main FSM: load count and samples, pick a mode, compute, show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD_N;
            n            <= '0;
            idx          <= '0;
            sum          <= '0;
            sumsq        <= '0;
            mode         <= MODE_SUM;
            use_div      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                LOAD_N: if (tick) begin
                    n      <= n_in;
                    result <= sat(ACC_W'(din));
                    idx    <= '0;
                    sum    <= '0;
                    sumsq  <= '0;
                    state  <= (n_in == '0) ? SELECT : LOAD_S;
                end
                LOAD_S: if (tick) begin
                    result <= sat(ACC_W'(din));
                    sum    <= sum + ACC_W'(din);
                    sumsq  <= sumsq + ACC_W'(din) * ACC_W'(din);
                    idx    <= idx + 1'b1;
                    if (NW'(idx + 1'b1) == n) state <= SELECT;
                end
                SELECT: if (tick) begin
                    mode    <= din_mode;
                    use_div <= need_div;
                    busy    <= 1'b1;
                    state   <= COMPUTE;
                end
                COMPUTE: begin
                    if (!use_div) begin
                        result       <= sat(direct_val);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= SHOW;
                    end else if (ds_done) begin
                        result       <= sat(ds_res);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= SHOW;
                    end
                end
                SHOW: if (tick && (din_mode != mode)) begin
                    mode         <= din_mode;
                    use_div      <= need_div;
                    result_valid <= 1'b0;
                    busy         <= 1'b1;
                    state        <= COMPUTE;
                end
                default: state <= LOAD_N;
            endcase
        end
    end

endmodule
